axi_wr_burst_packer: RTL

Burst-forming buffer that sits directly upstream of the AXI write master. It accepts a free-running data stream, stores it in a synchronous FIFO, and presents it downstream only in whole bursts of exactly BURST_LEN beats, each terminated by tlast. Gathering a complete burst before presenting it means the write master never stalls mid-burst waiting for data. A frame that ends on a partial burst (input tlast) is padded with PAD_WORD up to the next burst boundary.

---
 rtl/axi_wr_burst_packer_if.sv | 13 +
 rtl/axi_wr_burst_packer.sv | 118 +++++++++++
 2 files changed

// File: rtl/axi_wr_burst_packer_if.sv
// Stream handshake bundle shared by the packer input and output sides.
// The master drives data/valid/last; the slave returns ready.
interface axi_wr_burst_packer_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axi_wr_burst_packer.sv
// Burst-forming FIFO ahead of the AXI write master: output is released only
// in whole BURST_LEN-beat bursts, with partial frames padded to a burst boundary.
module axi_wr_burst_packer #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    BURST_LEN  = 16,
    parameter int                    FIFO_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0] PAD_WORD   = '0
) (
    input  logic                         S_WR_aclk,
    input  logic                         S_WR_areset,
    axi_wr_burst_packer_if.slave         s,
    axi_wr_burst_packer_if.master        m,
    output logic [$clog2(FIFO_DEPTH):0]  o_level,
    output logic                         o_padding,
    output logic [15:0]                  o_bursts
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CW = $clog2(FIFO_DEPTH / BURST_LEN) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic {ST_IN, ST_PAD} wr_state_t;

    wr_state_t             state, state_nxt;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [BW-1:0]         wr_beat, rd_beat;
    logic [CW-1:0]         ready_bursts;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  push, pop, full, empty, wr_last, rd_last;
    logic                  credit_inc, credit_dec;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_last = (wr_beat == LAST_BEAT);
    assign rd_last = (rd_beat == LAST_BEAT);
    assign o_level = wr_ptr - rd_ptr;

    always_ff @(posedge S_WR_aclk) begin
        if (S_WR_areset) begin
            state <= ST_IN;
        end else begin
            state <= state_nxt;
        end
    end

    // Write-side FSM: accept input beats, or fill the burst tail with PAD_WORD.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        wdata     = s.tdata;
        s.tready  = 1'b0;
        o_padding = 1'b0;
        case (state)
            ST_IN: begin
                s.tready = !full && !S_WR_areset;
                push     = s.tvalid && !full && !S_WR_areset;
                if (push && s.tlast && !wr_last) begin
                    state_nxt = ST_PAD;
                end
            end
            ST_PAD: begin
                o_padding = 1'b1;
                wdata     = PAD_WORD;
                push      = !full;
                if (push && wr_last) begin
                    state_nxt = ST_IN;
                end
            end
            default: state_nxt = ST_IN;
        endcase
    end

    // A burst is only offered once its last beat is resident; after the first
    // pop the remaining beats are guaranteed present, so rd_beat != 0 suffices.
    assign m.tvalid = !empty && ((rd_beat != '0) || (ready_bursts != '0));
    assign m.tlast  = m.tvalid && rd_last;
    assign m.tdata  = mem[rd_ptr[AW-1:0]];
    assign pop      = m.tvalid && m.tready;

    assign credit_inc = push && wr_last;
    assign credit_dec = pop && (rd_beat == '0);

    always_ff @(posedge S_WR_aclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge S_WR_aclk) begin
        if (S_WR_areset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wr_beat      <= '0;
            rd_beat      <= '0;
            ready_bursts <= '0;
            o_bursts     <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                wr_beat <= wr_last ? '0 : wr_beat + BW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                rd_beat <= rd_last ? '0 : rd_beat + BW'(1);
                if (rd_last) begin
                    o_bursts <= o_bursts + 16'd1;
                end
            end
            case ({credit_inc, credit_dec})
                2'b10:   ready_bursts <= ready_bursts + CW'(1);
                2'b01:   ready_bursts <= ready_bursts - CW'(1);
                default: ready_bursts <= ready_bursts;
            endcase
        end
    end
endmodule
